// File: rtl/pio_out_blink.sv
// pio_out_blink: Avalon-MM output PIO with set/clear/toggle and per-bit prescaled blink
module pio_out_blink #(
  parameter int DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int PRESCALE_WIDTH = 24,
  parameter logic [PRESCALE_WIDTH-1:0] RESET_PERIOD = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);
  logic [DATA_WIDTH-1:0] data, blink_en, wd_d, data_nxt;
  logic [PRESCALE_WIDTH-1:0] period, cnt, cnt_inc;
  logic phase, wr, unused_wd;
  assign wr = chipselect & ~write_n;
  assign wd_d = writedata[DATA_WIDTH-1:0];
  assign cnt_inc = cnt + PRESCALE_WIDTH'(1);
  assign unused_wd = ^writedata;
  assign out_port = data & (~blink_en | {DATA_WIDTH{phase}});
  // data register update from DATA / OUTSET / OUTCLR / OUTTGL writes
  always_comb begin
    data_nxt = !wr              ? data :
               address == 3'd0 ? wd_d :
               address == 3'd4 ? (data | wd_d) :
               address == 3'd5 ? (data & ~wd_d) :
               address == 3'd6 ? (data ^ wd_d) : data;
  end
  // register file and blink prescaler; a PERIOD write restarts the blink cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      data <= RESET_VALUE;
      blink_en <= '0;
      period <= RESET_PERIOD;
      cnt <= '0;
      phase <= 1'b1;
    end else begin
      data <= data_nxt;
      if (wr && address == 3'd1) blink_en <= wd_d;
      if (wr && address == 3'd2) begin
        period <= writedata[PRESCALE_WIDTH-1:0];
        cnt <= '0;
        phase <= 1'b1;
      end else if (period == '0) begin
        cnt <= '0;
        phase <= 1'b1;
      end else if (cnt_inc == period) begin
        cnt <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt_inc;
      end
    end
  end
  // combinational register readback, zero-extended
  always_comb begin
    readdata = address == 3'd0 ? 32'(data) :
               address == 3'd1 ? 32'(blink_en) :
               address == 3'd2 ? 32'(period) :
               address == 3'd3 ? 32'(out_port) : 32'd0;
  end
endmodule

// File: tb/tb_pio_out_blink.sv
// tb_pio_out_blink: directed scoreboard bench for pio_out_blink at widths 8, 1 and 32
module tb_pio_out_blink;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [2:0] address = '0;
  logic write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic cs8 = 1'b0, cs1 = 1'b0, cs32 = 1'b0;
  logic [31:0] rd8, rd1, rd32, out32;
  logic [7:0] out8;
  logic [0:0] out1;
  logic [31:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pio_out_blink u8 (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs8), .write_n(write_n),
    .writedata(writedata), .readdata(rd8), .out_port(out8)
  );

  pio_out_blink #(
    .DATA_WIDTH(1), .RESET_VALUE(1'b1), .PRESCALE_WIDTH(1), .RESET_PERIOD(1'b1)
  ) u1 (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs1), .write_n(write_n),
    .writedata(writedata), .readdata(rd1), .out_port(out1)
  );

  pio_out_blink #(
    .DATA_WIDTH(32), .RESET_VALUE(32'h3), .PRESCALE_WIDTH(24), .RESET_PERIOD(24'd2)
  ) u32 (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs32), .write_n(write_n),
    .writedata(writedata), .readdata(rd32), .out_port(out32)
  );

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %h, nothing expected in scoreboard", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] e);
    exp_q.push_back(e);
    check(tag, obs);
  endtask

  task automatic rd(input int which, input logic [2:0] a, input logic [31:0] e, input string tag);
    address = a;
    exp_q.push_back(e);
    #1;
    check(tag, which == 8 ? rd8 : which == 1 ? rd1 : rd32);
  endtask

  task automatic wr(input int which, input logic [2:0] a, input logic [31:0] d);
    address = a;
    writedata = d;
    write_n = 1'b0;
    cs8 = (which == 8);
    cs1 = (which == 1);
    cs32 = (which == 32);
    @(negedge clk);
    write_n = 1'b1;
    cs8 = 1'b0;
    cs1 = 1'b0;
    cs32 = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rd(32, 3'd0, 32'h3, "u32_rst_data");
    rd(32, 3'd2, 32'h2, "u32_rst_period");
    rd(32, 3'd1, 32'h0, "u32_rst_blink_en");
    wr(32, 3'd1, 32'hFFFF_FFFF);
    for (int j = 1; j <= 8; j++) begin
      if (j > 1) @(negedge clk);
      ck("u32_blink_p2", out32, ((j / 2) % 2 == 0) ? 32'h3 : 32'h0);
    end
    for (int a = 0; a < 8; a++) rd(8, 3'(a), 32'h0, "u8_rst_read");
    ck("u8_rst_out", 32'(out8), 32'h0);
    rd(1, 3'd0, 32'h1, "u1_rst_data");
    rd(1, 3'd1, 32'h0, "u1_rst_blink_en");
    rd(1, 3'd2, 32'h1, "u1_rst_period");
    rd(1, 3'd3, 32'h1, "u1_rst_out_reg");
    ck("u1_rst_out", 32'(out1), 32'h1);
    @(negedge clk);
    wr(8, 3'd0, 32'hA5);
    rd(8, 3'd0, 32'hA5, "data_wr");
    wr(8, 3'd4, 32'h0F);
    ck("outset", 32'(out8), 32'hAF);
    rd(8, 3'd3, 32'hAF, "outset_reg");
    wr(8, 3'd5, 32'h81);
    ck("outclr", 32'(out8), 32'h2E);
    wr(8, 3'd6, 32'hFF);
    ck("outtgl", 32'(out8), 32'hD1);
    rd(8, 3'd0, 32'hD1, "outtgl_data");
    wr(8, 3'd7, 32'h55);
    rd(8, 3'd0, 32'hD1, "addr7_wr_ignored");
    rd(8, 3'd7, 32'h0, "addr7_read");
    wr(8, 3'd3, 32'h00);
    rd(8, 3'd0, 32'hD1, "out_reg_wr_ignored");
    address = 3'd0;
    writedata = 32'h0;
    write_n = 1'b0;
    @(negedge clk);
    write_n = 1'b1;
    rd(8, 3'd0, 32'hD1, "cs0_wr_ignored");
    wr(8, 3'd0, 32'hFFFF_FF12);
    rd(8, 3'd0, 32'h12, "wd_upper_ignored");
    wr(8, 3'd0, 32'hFF);
    wr(8, 3'd1, 32'h0F);
    rd(8, 3'd1, 32'h0F, "blink_en_rd");
    ck("blink_off_steady", 32'(out8), 32'hFF);
    wr(8, 3'd2, 32'd4);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      ck("blink_p4", 32'(out8), ((i / 4) % 2 == 0) ? 32'hFF : 32'hF0);
      rd(8, 3'd3, ((i / 4) % 2 == 0) ? 32'hFF : 32'hF0, "blink_p4_out_reg");
    end
    wr(8, 3'd2, 32'd1);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      ck("blink_p1", 32'(out8), (k % 2 == 0) ? 32'hFF : 32'hF0);
    end
    wr(8, 3'd2, 32'd0);
    rd(8, 3'd2, 32'h0, "period0_rd");
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      ck("period0_steady", 32'(out8), 32'hFF);
    end
    wr(8, 3'd2, 32'd4);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      ck("wrap_pre", 32'(out8), 32'hFF);
    end
    @(negedge clk);
    wr(8, 3'd2, 32'd4);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      ck("wrap_restart", 32'(out8), (i < 4) ? 32'hFF : 32'hF0);
    end
    reset = 1'b1;
    address = 3'd0;
    writedata = 32'h77;
    write_n = 1'b0;
    cs8 = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    write_n = 1'b1;
    cs8 = 1'b0;
    ck("midblink_rst_out", 32'(out8), 32'h0);
    rd(8, 3'd0, 32'h0, "rst_beats_wr");
    rd(8, 3'd1, 32'h0, "rst_blink_en");
    rd(8, 3'd2, 32'h0, "rst_period");
    @(negedge clk);
    wr(8, 3'd0, 32'hFF);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      ck("post_rst_steady", 32'(out8), 32'hFF);
    end
    @(negedge clk);
    wr(1, 3'd2, 32'hFFFF_FFFE);
    rd(1, 3'd2, 32'h0, "u1_period_trunc0");
    wr(1, 3'd2, 32'h3);
    rd(1, 3'd2, 32'h1, "u1_period_trunc1");
    wr(1, 3'd0, 32'hFFFF_FFFE);
    rd(1, 3'd0, 32'h0, "u1_wd_upper");
    ck("u1_out_cleared", 32'(out1), 32'h0);
    wr(1, 3'd0, 32'h1);
    wr(1, 3'd1, 32'h1);
    for (int n = 3; n < 7; n++) begin
      if (n > 3) @(negedge clk);
      ck("u1_blink_p1", 32'(out1), (n % 2 == 0) ? 32'h1 : 32'h0);
    end
    @(negedge clk);
    wr(32, 3'd0, 32'hDEAD_BEEF);
    rd(32, 3'd0, 32'hDEAD_BEEF, "u32_data_full");
    ck("u32_out_full", out32, 32'hDEAD_BEEF);
    wr(32, 3'd1, 32'h8000_0001);
    rd(32, 3'd1, 32'h8000_0001, "u32_blink_en_full");
    wr(32, 3'd2, 32'hFFFF_FFFF);
    rd(32, 3'd2, 32'h00FF_FFFF, "u32_period_trunc");
    ck("u32_out_restart", out32, 32'hDEAD_BEEF);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
